// File: rtl/_dff_pipe_r.sv
// Parameterised register pipeline carrying data plus a valid flag per stage,
// with async reset, sync clear, stall enable and a live count of valid stages.
module _dff_pipe_r #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sclr,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]    cnt_c;

  // Next-state: clear beats advance beats hold; data shifts regardless of valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (sclr) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_d[k] = RESET_VAL;
      end
      valid_d = '0;
    end else if (en) begin
      data_d[0]  = d;
      valid_d[0] = in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VAL;
      end
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Population count of the valid flags; range 0..DEPTH fits CW bits.
  always_comb begin
    cnt_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_c = cnt_c + CW'(valid_q[k]);
    end
  end

  assign q         = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign count     = cnt_c;

endmodule

// File: tb/tb__dff_pipe_r.sv
// Directed bench for _dff_pipe_r: default 8x4 pipe, a 1x1 pipe with
// RESET_VAL=1, and an 8x16 pipe for the long-latency case.
module tb__dff_pipe_r;

  logic clk;
  logic reset;

  logic       sclr, en, in_valid;
  logic [7:0] d, q;
  logic       out_valid;
  logic [2:0] count;

  logic sclr1, en1, in_valid1, d1, q1, out_valid1;
  logic [0:0] count1;

  logic       sclr16, en16, in_valid16;
  logic [7:0] d16, q16;
  logic       out_valid16;
  logic [4:0] count16;

  int checks = 0;
  int errors = 0;

  _dff_pipe_r #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .reset(reset), .sclr(sclr), .en(en), .in_valid(in_valid),
    .d(d), .q(q), .out_valid(out_valid), .count(count)
  );

  _dff_pipe_r #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .sclr(sclr1), .en(en1), .in_valid(in_valid1),
    .d(d1), .q(q1), .out_valid(out_valid1), .count(count1)
  );

  _dff_pipe_r #(.WIDTH(8), .DEPTH(16), .RESET_VAL(8'h00)) u_dut16 (
    .clk(clk), .reset(reset), .sclr(sclr16), .en(en16), .in_valid(in_valid16),
    .d(d16), .q(q16), .out_valid(out_valid16), .count(count16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    sclr = 0; en = 0; in_valid = 0; d = 8'h00;
    sclr1 = 0; en1 = 0; in_valid1 = 0; d1 = 1'b0;
    sclr16 = 0; en16 = 0; in_valid16 = 0; d16 = 8'h00;

    // Async reset values before any clock edge
    #3;
    check("rst_q", 64'(q), 64'h00);
    check("rst_ov", 64'(out_valid), 64'h0);
    check("rst_cnt", 64'(count), 64'h0);
    check("rst_q1", 64'(q1), 64'h1);
    check("rst_cnt16", 64'(count16), 64'h0);
    step();
    step();
    reset = 1'b0;

    // DEPTH=1 single DFF
    en1 = 1; in_valid1 = 1; d1 = 1'b0;
    step();
    check("d1_q", 64'(q1), 64'h0);
    check("d1_ov", 64'(out_valid1), 64'h1);
    check("d1_cnt", 64'(count1), 64'h1);
    en1 = 0; sclr1 = 1;
    step();
    check("d1_sclr_q", 64'(q1), 64'h1);
    check("d1_sclr_ov", 64'(out_valid1), 64'h0);
    sclr1 = 0;

    // Fill and drain
    en = 1; in_valid = 1;
    d = 8'h11; step(); check("fill_cnt1", 64'(count), 64'h1);
    d = 8'h22; step(); check("fill_cnt2", 64'(count), 64'h2);
    d = 8'h33; step(); check("fill_cnt3", 64'(count), 64'h3);
    check("fill_ov3", 64'(out_valid), 64'h0);
    d = 8'h44; step(); check("fill_cnt4", 64'(count), 64'h4);
    check("fill_q4", 64'(q), 64'h11);
    check("fill_ov4", 64'(out_valid), 64'h1);
    in_valid = 0; d = 8'h00;
    step(); check("drain_cnt3", 64'(count), 64'h3); check("drain_q22", 64'(q), 64'h22);
    step(); check("drain_cnt2", 64'(count), 64'h2); check("drain_q33", 64'(q), 64'h33);
    step(); check("drain_cnt1", 64'(count), 64'h1); check("drain_q44", 64'(q), 64'h44);
    step(); check("drain_cnt0", 64'(count), 64'h0); check("drain_ov0", 64'(out_valid), 64'h0);

    // Stall with two words in flight
    in_valid = 1;
    d = 8'hA1; step();
    d = 8'hA2; step();
    check("stall_pre_cnt", 64'(count), 64'h2);
    en = 0;
    d = 8'h5C; step();
    d = 8'h6D; step();
    d = 8'h7E; step();
    check("stall_cnt", 64'(count), 64'h2);
    check("stall_q", 64'(q), 64'h00);
    check("stall_ov", 64'(out_valid), 64'h0);
    en = 1; in_valid = 0; d = 8'h00;
    step(); check("resume1_ov", 64'(out_valid), 64'h0);
    step(); check("resume2_q", 64'(q), 64'hA1);
    check("resume2_ov", 64'(out_valid), 64'h1);
    check("resume2_cnt", 64'(count), 64'h2);
    step(); check("resume3_q", 64'(q), 64'hA2);
    check("resume3_cnt", 64'(count), 64'h1);

    // Sync clear waits for the edge
    in_valid = 1;
    d = 8'h01; step();
    d = 8'h02; step();
    d = 8'h03; step();
    d = 8'h04; step();
    check("sclr_full_cnt", 64'(count), 64'h4);
    en = 0; sclr = 1;
    #2;
    check("sclr_pre_q", 64'(q), 64'h01);
    check("sclr_pre_cnt", 64'(count), 64'h4);
    step();
    check("sclr_q", 64'(q), 64'h00);
    check("sclr_cnt", 64'(count), 64'h0);
    check("sclr_ov", 64'(out_valid), 64'h0);
    sclr = 0;

    // Async reset mid-stream, then edges ignored while held
    en = 1;
    d = 8'h05; step();
    d = 8'h06; step();
    d = 8'h07; step();
    d = 8'h08; step();
    check("ar_full_q", 64'(q), 64'h05);
    en = 0;
    #2;
    reset = 1'b1;
    #1;
    check("ar_q", 64'(q), 64'h00);
    check("ar_ov", 64'(out_valid), 64'h0);
    check("ar_cnt", 64'(count), 64'h0);
    en = 1; d = 8'h99;
    step();
    check("ar_held_cnt", 64'(count), 64'h0);
    reset = 1'b0;
    step();
    check("ar_release_cnt", 64'(count), 64'h1);

    // sclr beats en on the same edge
    sclr = 1; en = 1; in_valid = 1; d = 8'hFF;
    step();
    check("prio_cnt", 64'(count), 64'h0);
    check("prio_ov", 64'(out_valid), 64'h0);
    sclr = 0; in_valid = 0; d = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("prio_q_%0d", i), 64'(q), 64'h00);
      check($sformatf("prio_ov_%0d", i), 64'(out_valid), 64'h0);
    end
    en = 0;

    // DEPTH=16 latency with two stalled edges mid-flight
    en16 = 1; in_valid16 = 1; d16 = 8'h5A;
    step();
    in_valid16 = 0; d16 = 8'h00;
    for (int e = 2; e <= 15; e++) begin
      if (e == 8) begin
        en16 = 0;
        step();
        step();
        en16 = 1;
      end
      step();
      check($sformatf("d16_early_%0d", e), 64'(out_valid16), 64'h0);
    end
    step();
    check("d16_q", 64'(q16), 64'h5A);
    check("d16_ov", 64'(out_valid16), 64'h1);
    check("d16_cnt", 64'(count16), 64'h1);
    step();
    check("d16_after_cnt", 64'(count16), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
